// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// Package : mem_arb_pkg
// Purpose : Shared types and constants for the unified memory port arbiter
//           that sits between the IF and MEM stages of the 5-stage pipeline.
// Contents: arb_state_t  - arbiter FSM states
//           SZ_B/H/W     - access size encodings (byte / half / word)
//           GRANT_I/D    - encodings of the last-grant register
//           mem_req_t    - latched memory request (we, size, addr, wdata)
//           fetch_req()  - builds the fixed-format fetch request
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  // Width of the latched request fields; the arbiter's AWIDTH/DWIDTH
  // parameters default to these and must match them.
  localparam int MEM_AWIDTH = 32;
  localparam int MEM_DWIDTH = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_REQ  = 3'd1,
    I_WAIT = 3'd2,
    D_REQ  = 3'd3,
    D_WAIT = 3'd4
  } arb_state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  typedef struct packed {
    logic                  we;
    logic [1:0]            size;
    logic [MEM_AWIDTH-1:0] addr;
    logic [MEM_DWIDTH-1:0] wdata;
  } mem_req_t;

  // Instruction fetches are always word reads with no write data.
  function automatic mem_req_t fetch_req(input logic [MEM_AWIDTH-1:0] pc);
    mem_req_t r;
    r.we    = 1'b0;
    r.size  = SZ_W;
    r.addr  = pc;
    r.wdata = '0;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// Module  : mem_port_arbiter
// Purpose : Shares one memory port between the instruction-fetch requester
//           and the MEM-stage load/store requester. One transaction is in
//           flight at a time; ties alternate between the two sides. Fetch
//           responses belonging to a flushed fetch are swallowed. A wait
//           counter aborts transactions that never complete.
// Ports   : clk, reset (async, active-high)
//           if_req/if_addr/if_kill   -> if_valid/if_rdata/if_stall
//           d_req/d_we/d_size/d_addr/d_wdata -> d_valid/d_rdata/d_stall
//           mem_req/mem_we/mem_size/mem_addr/mem_wdata <- mem_ready
//           mem_rvalid/mem_rdata     (response / store acknowledge)
//           err                      (sticky timeout flag)
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH  = MEM_AWIDTH,
  parameter int DWIDTH  = MEM_DWIDTH,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  // instruction fetch side
  input  logic              if_req,
  input  logic [AWIDTH-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_valid,
  output logic [DWIDTH-1:0] if_rdata,
  output logic              if_stall,
  // data side
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  output logic              d_valid,
  output logic [DWIDTH-1:0] d_rdata,
  output logic              d_stall,
  // memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DWIDTH-1:0] mem_rdata,
  // status
  output logic              err
);

  localparam logic [7:0] c_timeout = 8'(TIMEOUT);

  arb_state_t r_state, w_state_nxt;
  logic       r_last_grant, w_last_grant_nxt;
  logic       r_drop, w_drop_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_err, w_err_nxt;
  mem_req_t   r_req, w_req_nxt;

  logic       w_if_ok;
  logic       w_in_xfer;
  logic       w_timeout;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_D;
      r_drop       <= 1'b0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_req        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_drop       <= w_drop_nxt;
      r_cnt        <= w_cnt_nxt;
      r_err        <= w_err_nxt;
      r_req        <= w_req_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_drop_nxt       = r_drop;
    w_err_nxt        = r_err;
    w_req_nxt        = r_req;
    mem_req          = 1'b0;
    if_valid         = 1'b0;
    if_rdata         = '0;
    d_valid          = 1'b0;
    d_rdata          = '0;

    // A killed fetch in IDLE is not a request for this cycle.
    w_if_ok   = if_req & ~if_kill;
    w_in_xfer = (r_state != IDLE);
    w_timeout = w_in_xfer && (r_cnt == c_timeout);
    w_cnt_nxt = w_in_xfer ? r_cnt + 8'd1 : r_cnt;

    case (r_state)
      IDLE: begin
        // Data wins when it is alone or when fetch had the previous grant.
        if (d_req && (!w_if_ok || r_last_grant == GRANT_I)) begin
          w_state_nxt      = D_REQ;
          w_last_grant_nxt = GRANT_D;
          w_cnt_nxt        = '0;
          w_req_nxt.we     = d_we;
          w_req_nxt.size   = d_size;
          w_req_nxt.addr   = d_addr;
          w_req_nxt.wdata  = d_wdata;
        end else if (w_if_ok) begin
          w_state_nxt      = I_REQ;
          w_last_grant_nxt = GRANT_I;
          w_cnt_nxt        = '0;
          w_req_nxt        = fetch_req(if_addr);
        end
      end

      I_REQ: begin
        mem_req = 1'b1;
        if (if_kill) w_drop_nxt = 1'b1;
        if (w_timeout) begin
          w_state_nxt = IDLE;
          w_err_nxt   = 1'b1;
        end else if (mem_ready) begin
          w_state_nxt = I_WAIT;
        end
      end

      I_WAIT: begin
        if (if_kill) w_drop_nxt = 1'b1;
        // A real response takes precedence over a coincident timeout.
        if (mem_rvalid) begin
          w_state_nxt = IDLE;
          if (!r_drop && !if_kill) begin
            if_valid = 1'b1;
            if_rdata = mem_rdata;
          end
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
          w_err_nxt   = 1'b1;
        end
      end

      D_REQ: begin
        mem_req = 1'b1;
        if (w_timeout) begin
          // Release the MEM stage with zero data so the pipeline cannot hang.
          w_state_nxt = IDLE;
          w_err_nxt   = 1'b1;
          d_valid     = 1'b1;
        end else if (mem_ready) begin
          w_state_nxt = D_WAIT;
        end
      end

      D_WAIT: begin
        if (mem_rvalid) begin
          w_state_nxt = IDLE;
          d_valid     = 1'b1;
          d_rdata     = mem_rdata;
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
          w_err_nxt   = 1'b1;
          d_valid     = 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_state_nxt == IDLE) w_drop_nxt = 1'b0;
  end

  assign if_stall  = if_req & ~if_valid & ~if_kill;
  assign d_stall   = d_req & ~d_valid;

  assign mem_we    = r_req.we;
  assign mem_size  = r_req.size;
  assign mem_addr  = r_req.addr;
  assign mem_wdata = r_req.wdata;
  assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_kill;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(
    .AWIDTH (32),
    .DWIDTH (32),
    .TIMEOUT(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_kill   (if_kill),
    .if_valid  (if_valid),
    .if_rdata  (if_rdata),
    .if_stall  (if_stall),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_size    (d_size),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_valid   (d_valid),
    .d_rdata   (d_rdata),
    .d_stall   (d_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_size  (mem_size),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge; inputs are driven there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_size = 2'd0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #2;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_d_valid", {31'd0, d_valid}, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);

    // ---------------- lone load ----------------
    tick(); reset = 1'b0;
    d_req = 1'b1; d_addr = 32'h100; d_we = 1'b0; d_size = 2'd2;
    #1;                                   // cycle 0
    chk("ld_c0_d_stall", {31'd0, d_stall}, 32'd1);
    chk("ld_c0_mem_req", {31'd0, mem_req}, 32'd0);
    tick(); mem_ready = 1'b1; #1;         // cycle 1
    chk("ld_c1_mem_req", {31'd0, mem_req}, 32'd1);
    chk("ld_c1_mem_addr", mem_addr, 32'h100);
    chk("ld_c1_mem_we", {31'd0, mem_we}, 32'd0);
    chk("ld_c1_d_stall", {31'd0, d_stall}, 32'd1);
    tick(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; #1;  // cycle 2
    chk("ld_c2_d_valid", {31'd0, d_valid}, 32'd1);
    chk("ld_c2_d_rdata", d_rdata, 32'hDEADBEEF);
    chk("ld_c2_d_stall", {31'd0, d_stall}, 32'd0);
    chk("ld_c2_mem_req", {31'd0, mem_req}, 32'd0);
    tick(); d_req = 1'b0; mem_rvalid = 1'b0; #1;  // cycle 3
    chk("ld_c3_d_valid", {31'd0, d_valid}, 32'd0);

    // ---------------- tie: fetch, data, fetch ----------------
    tick(); reset = 1'b1; #1;
    chk("tie_rst_mem_req", {31'd0, mem_req}, 32'd0);
    tick(); reset = 1'b0;
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b1; d_size = 2'd0; d_addr = 32'h300; d_wdata = 32'h55;
    #1;
    chk("tie_c0_if_stall", {31'd0, if_stall}, 32'd1);
    chk("tie_c0_d_stall", {31'd0, d_stall}, 32'd1);
    tick(); mem_ready = 1'b1; #1;
    chk("tie_g1_mem_addr", mem_addr, 32'h200);
    chk("tie_g1_mem_we", {31'd0, mem_we}, 32'd0);
    chk("tie_g1_mem_size", {30'd0, mem_size}, 32'd2);
    tick(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11111111; #1;
    chk("tie_g1_if_valid", {31'd0, if_valid}, 32'd1);
    chk("tie_g1_if_rdata", if_rdata, 32'h11111111);
    chk("tie_g1_d_valid", {31'd0, d_valid}, 32'd0);
    tick(); mem_rvalid = 1'b0; if_addr = 32'h204; #1;
    chk("tie_idle_mem_req", {31'd0, mem_req}, 32'd0);
    tick(); mem_ready = 1'b1; #1;
    chk("tie_g2_mem_addr", mem_addr, 32'h300);
    chk("tie_g2_mem_we", {31'd0, mem_we}, 32'd1);
    chk("tie_g2_mem_size", {30'd0, mem_size}, 32'd0);
    chk("tie_g2_mem_wdata", mem_wdata, 32'h55);
    tick(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0; #1;
    chk("tie_g2_d_valid", {31'd0, d_valid}, 32'd1);
    chk("tie_g2_if_valid", {31'd0, if_valid}, 32'd0);
    tick(); mem_rvalid = 1'b0; d_req = 1'b0; #1;
    chk("tie_idle2_if_stall", {31'd0, if_stall}, 32'd1);
    tick(); mem_ready = 1'b1; #1;
    chk("tie_g3_mem_addr", mem_addr, 32'h204);
    chk("tie_g3_mem_req", {31'd0, mem_req}, 32'd1);
    tick(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h22222222; #1;
    chk("tie_g3_if_rdata", if_rdata, 32'h22222222);
    tick(); mem_rvalid = 1'b0; if_req = 1'b0; #1;

    // ---------------- kill in I_WAIT ----------------
    if_req = 1'b1; if_addr = 32'h40;
    #1;                                   // IDLE
    tick(); mem_ready = 1'b1; #1;         // I_REQ
    chk("kill_mem_addr", mem_addr, 32'h40);
    tick(); mem_ready = 1'b0; if_kill = 1'b1; #1;  // I_WAIT, kill
    chk("kill_if_stall", {31'd0, if_stall}, 32'd0);
    chk("kill_if_valid0", {31'd0, if_valid}, 32'd0);
    tick(); if_kill = 1'b0; if_addr = 32'h80; mem_rvalid = 1'b1; mem_rdata = 32'h40404040; #1;
    chk("kill_dropped", {31'd0, if_valid}, 32'd0);
    chk("kill_stall_new", {31'd0, if_stall}, 32'd1);
    tick(); mem_rvalid = 1'b0; #1;        // IDLE
    chk("kill_idle_mem_req", {31'd0, mem_req}, 32'd0);
    tick(); mem_ready = 1'b1; #1;         // I_REQ for 0x80
    chk("kill_new_addr", mem_addr, 32'h80);
    tick(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80808080; #1;
    chk("kill_new_valid", {31'd0, if_valid}, 32'd1);
    chk("kill_new_rdata", if_rdata, 32'h80808080);
    tick(); mem_rvalid = 1'b0; if_req = 1'b0; #1;

    // ---------------- backpressure ----------------
    d_req = 1'b1; d_we = 1'b1; d_size = 2'd1; d_addr = 32'h500; d_wdata = 32'hCAFEF00D;
    #1;                                   // IDLE
    for (int i = 0; i < 2; i++) begin
      tick();
      d_addr = 32'hBAD0 + i; d_wdata = 32'h0; // fields must stay latched
      #1;
      chk("bp_mem_req", {31'd0, mem_req}, 32'd1);
      chk("bp_mem_addr", mem_addr, 32'h500);
      chk("bp_mem_wdata", mem_wdata, 32'hCAFEF00D);
    end
    tick(); mem_ready = 1'b1; #1;
    chk("bp_ready_mem_req", {31'd0, mem_req}, 32'd1);
    chk("bp_ready_size", {30'd0, mem_size}, 32'd1);
    tick(); mem_ready = 1'b0; #1;         // D_WAIT
    chk("bp_wait_mem_req", {31'd0, mem_req}, 32'd0);
    mem_rvalid = 1'b1; #1;
    chk("bp_d_valid", {31'd0, d_valid}, 32'd1);
    tick(); mem_rvalid = 1'b0; d_req = 1'b0; #1;

    // ---------------- timeout on a store ----------------
    d_req = 1'b1; d_we = 1'b1; d_size = 2'd2; d_addr = 32'h600; d_wdata = 32'h12345678;
    #1;                                   // IDLE
    tick(); mem_ready = 1'b1; #1;         // D_REQ entry (count 0)
    chk("to_entry_mem_req", {31'd0, mem_req}, 32'd1);
    tick(); mem_ready = 1'b0; mem_rdata = 32'hFFFFFFFF; #1;
    for (int i = 0; i < 3; i++) begin
      chk("to_wait_d_valid", {31'd0, d_valid}, 32'd0);
      chk("to_wait_err", {31'd0, err}, 32'd0);
      tick(); #1;
    end
    chk("to_d_valid", {31'd0, d_valid}, 32'd1);
    chk("to_d_rdata", d_rdata, 32'h0);
    tick(); d_req = 1'b0; #1;
    chk("to_err_set", {31'd0, err}, 32'd1);
    chk("to_idle_mem_req", {31'd0, mem_req}, 32'd0);
    repeat (3) tick();
    #1;
    chk("to_err_sticky", {31'd0, err}, 32'd1);

    // ---------------- reset in D_WAIT ----------------
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700;
    #1;
    tick(); mem_ready = 1'b1; #1;         // D_REQ
    tick(); mem_ready = 1'b0; #1;         // D_WAIT
    chk("rw_in_wait_req", {31'd0, mem_req}, 32'd0);
    reset = 1'b1; d_req = 1'b0; #1;
    chk("rw_err_cleared", {31'd0, err}, 32'd0);
    chk("rw_mem_addr", mem_addr, 32'h0);
    chk("rw_d_valid", {31'd0, d_valid}, 32'd0);
    tick(); reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77; #1;
    chk("rw_late_d_valid", {31'd0, d_valid}, 32'd0);
    chk("rw_late_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rw_late_mem_req", {31'd0, mem_req}, 32'd0);
    tick(); mem_rvalid = 1'b0; #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
